// File: rtl/aud_stream_sched.sv
// Round-robin scheduler granting one of N_SRC PCM sources per whole stereo pair onto the I2S audio stream.
// Optional build macro AUD_SCHED_MUTE_EN adds mute_mask to zero tdata[15:0] of muted sources.
module aud_stream_sched #(
    parameter int N_SRC           = 4,
    parameter int PAIRS_PER_GRANT = 1,
    parameter int IDX_W           = $clog2(N_SRC)
) (
    input  logic                 s_axis_aud_aclk,
    input  logic                 s_axis_aud_aresetn,
    input  logic [N_SRC-1:0]     src_en,
`ifdef AUD_SCHED_MUTE_EN
    input  logic [N_SRC-1:0]     mute_mask,
`endif
    input  logic [N_SRC*32-1:0]  s_src_tdata,
    input  logic [N_SRC-1:0]     s_src_tvalid,
    output logic [N_SRC-1:0]     s_src_tready,
    output logic [31:0]          m_axis_aud_tdata,
    output logic [2:0]           m_axis_aud_tid,
    output logic                 m_axis_aud_tvalid,
    input  logic                 m_axis_aud_tready,
    output logic                 grant_valid_o,
    output logic [IDX_W-1:0]     grant_idx_o,
    output logic [31:0]          pair_cnt_o,
    output logic [1:0]           dbg_state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LEFT  = 2'd1;
    localparam logic [1:0] ST_RIGHT = 2'd2;

    logic [1:0]       state;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] ptr;
    logic [7:0]       pairs_done;
    logic [31:0]      pair_cnt;
    logic             out_valid;
    logic [31:0]      out_data;
    logic [2:0]       out_tid;

    logic [N_SRC-1:0] req;
    logic             hit_hi, hit_lo, hit;
    logic [IDX_W-1:0] idx_hi, idx_lo, hit_idx;
    logic             sel_valid, sel_en;
    logic [31:0]      sel_data, beat_data;
    logic             slot_free, serving, beat_go, more_pairs;

    // Handshake: a beat moves on any edge where valid && ready; the source side is
    // ready only for the granted source while the single output slot is empty or draining.
    assign slot_free = !out_valid || m_axis_aud_tready;
    assign serving   = grant_valid && (state == ST_LEFT || state == ST_RIGHT) && slot_free;
    assign beat_go   = serving && sel_valid;
    assign req       = src_en & s_src_tvalid;

    // First requester strictly above ptr wins, else the lowest at or below it (wrap).
    always_comb begin
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        idx_hi = '0;
        idx_lo = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (IDX_W'(i) > ptr) begin
                    hit_hi = 1'b1;
                    idx_hi = IDX_W'(i);
                end else begin
                    hit_lo = 1'b1;
                    idx_lo = IDX_W'(i);
                end
            end
        end
        hit     = hit_hi || hit_lo;
        hit_idx = hit_hi ? idx_hi : idx_lo;
    end

    always_comb begin
        sel_valid    = 1'b0;
        sel_en       = 1'b0;
        sel_data     = '0;
        s_src_tready = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                sel_valid       = s_src_tvalid[i];
                sel_en          = src_en[i];
                sel_data        = s_src_tdata[32*i +: 32];
                s_src_tready[i] = serving;
            end
        end
    end

    assign more_pairs = (({24'd0, pairs_done} + 32'd1) < 32'(PAIRS_PER_GRANT)) && sel_en && sel_valid;

`ifdef AUD_SCHED_MUTE_EN
    logic mute_hold;

    always_ff @(posedge s_axis_aud_aclk) begin
        if (!s_axis_aud_aresetn) begin
            mute_hold <= 1'b0;
        end else if (state == ST_IDLE && hit) begin
            mute_hold <= mute_mask[hit_idx];
        end
    end

    assign beat_data = mute_hold ? {sel_data[31:16], 16'h0000} : sel_data;
`else
    assign beat_data = sel_data;
`endif

    always_ff @(posedge s_axis_aud_aclk) begin
        if (!s_axis_aud_aresetn) begin
            state       <= ST_IDLE;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            ptr         <= IDX_W'(N_SRC - 1);
            pairs_done  <= '0;
            pair_cnt    <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_tid     <= '0;
        end else begin
            if (beat_go) begin
                out_valid <= 1'b1;
                out_data  <= beat_data;
                out_tid   <= {2'b00, state == ST_RIGHT};
            end else if (m_axis_aud_tready) begin
                out_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (hit) begin
                        grant_idx   <= hit_idx;
                        grant_valid <= 1'b1;
                        pairs_done  <= '0;
                        state       <= ST_LEFT;
                    end
                end
                ST_LEFT: begin
                    if (beat_go) state <= ST_RIGHT;
                end
                ST_RIGHT: begin
                    if (beat_go) begin
                        pair_cnt <= pair_cnt + 32'd1;
                        if (more_pairs) begin
                            pairs_done <= pairs_done + 8'd1;
                            state      <= ST_LEFT;
                        end else begin
                            grant_valid <= 1'b0;
                            ptr         <= grant_idx;
                            state       <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign m_axis_aud_tdata  = out_data;
    assign m_axis_aud_tid    = out_tid;
    assign m_axis_aud_tvalid = out_valid;
    assign grant_valid_o     = grant_valid;
    assign grant_idx_o       = grant_idx;
    assign pair_cnt_o        = pair_cnt;
    assign dbg_state         = state;

endmodule

// File: tb/tb_aud_stream_sched.sv
// Directed bench for aud_stream_sched: vector table for single-source timing, scoreboarded multi-cycle sequences.
// Two instances share the source inputs: one with PAIRS_PER_GRANT = 1, one with 3.
module tb_aud_stream_sched;

    localparam int N    = 4;
    localparam int SB_W = 33;

    logic              clk = 1'b0;
    logic              aresetn;
    logic [N-1:0]      src_en;
    logic [N*32-1:0]   s_src_tdata;
    logic [N-1:0]      s_src_tvalid;
    logic              m_tready;
`ifdef AUD_SCHED_MUTE_EN
    logic [N-1:0]      mute_mask;
`endif

    logic [N-1:0] rdy1, rdy3;
    logic [31:0]  md1, md3, pc1, pc3;
    logic [2:0]   mt1, mt3;
    logic         mv1, mv3, gv1, gv3;
    logic [1:0]   gi1, gi3, st1, st3;

    int n_tests = 0;
    int n_fail  = 0;
    int onehot_viol = 0;
    int forb_viol   = 0;
    logic [N-1:0]  forbid = '0;
    logic          use3 = 1'b0;
    logic          sb_on = 1'b0;
    logic [15:0]   seq[N];
    logic [15:0]   src_hi[N];
    logic [SB_W-1:0] exp_q[$];

    typedef struct {
        logic [3:0]  en;
        logic [3:0]  vld;
        logic [15:0] d0;
        logic        rdy;
        logic [3:0]  e_rdy;
        logic        e_mv;
        logic [31:0] e_d;
        logic [2:0]  e_tid;
        logic        e_gv;
        logic [1:0]  e_gi;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[16];

    aud_stream_sched #(.N_SRC(N), .PAIRS_PER_GRANT(1)) dut (
        .s_axis_aud_aclk(clk), .s_axis_aud_aresetn(aresetn), .src_en(src_en),
`ifdef AUD_SCHED_MUTE_EN
        .mute_mask(mute_mask),
`endif
        .s_src_tdata(s_src_tdata), .s_src_tvalid(s_src_tvalid), .s_src_tready(rdy1),
        .m_axis_aud_tdata(md1), .m_axis_aud_tid(mt1), .m_axis_aud_tvalid(mv1),
        .m_axis_aud_tready(m_tready), .grant_valid_o(gv1), .grant_idx_o(gi1),
        .pair_cnt_o(pc1), .dbg_state(st1)
    );

    aud_stream_sched #(.N_SRC(N), .PAIRS_PER_GRANT(3)) dut3 (
        .s_axis_aud_aclk(clk), .s_axis_aud_aresetn(aresetn), .src_en(src_en),
`ifdef AUD_SCHED_MUTE_EN
        .mute_mask(mute_mask),
`endif
        .s_src_tdata(s_src_tdata), .s_src_tvalid(s_src_tvalid), .s_src_tready(rdy3),
        .m_axis_aud_tdata(md3), .m_axis_aud_tid(mt3), .m_axis_aud_tvalid(mv3),
        .m_axis_aud_tready(m_tready), .grant_valid_o(gv3), .grant_idx_o(gi3),
        .pair_cnt_o(pc3), .dbg_state(st3)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic update_src();
        for (int i = 0; i < N; i++) s_src_tdata[32*i +: 32] = {src_hi[i], seq[i]};
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        exp_q.delete();
        forbid = '0;
        sb_on  = 1'b0;
        for (int i = 0; i < N; i++) begin
            seq[i]    = 16'h0000;
            src_hi[i] = {4'(i), 12'h000};
        end
`ifdef AUD_SCHED_MUTE_EN
        mute_mask = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        aresetn = 1'b1;
    endtask

    // One clock of the source/sink models, with the scoreboard watching the selected instance.
    task automatic tick();
        logic [N-1:0] rdy, acc;
        logic         mv;
        logic [31:0]  md;
        logic [2:0]   mt;
        #1;
        rdy = use3 ? rdy3 : rdy1;
        mv  = use3 ? mv3 : mv1;
        md  = use3 ? md3 : md1;
        mt  = use3 ? mt3 : mt1;
        acc = rdy & s_src_tvalid;
        if ($countones(rdy) > 1) onehot_viol++;
        if ((rdy & forbid) != '0) forb_viol++;
        if (sb_on && mv && m_tready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_extra_beat: got tid %0d data %h, expected no beat", mt, md);
            end else begin
                check("sb_beat", {31'd0, mt[0], md}, {31'd0, exp_q.pop_front()});
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (acc[i]) seq[i] = seq[i] + 16'd1;
        update_src();
    endtask

    task automatic push_pair(input int src, input logic [15:0] lo_seq, input logic mute);
        logic [15:0] a, b;
        a = mute ? 16'h0000 : lo_seq;
        b = mute ? 16'h0000 : lo_seq + 16'd1;
        exp_q.push_back({1'b0, src_hi[src], a});
        exp_q.push_back({1'b1, src_hi[src], b});
    endtask

    task automatic drain(input string name, input int budget, output int cycles);
        cycles = 0;
        while (exp_q.size() != 0 && cycles < budget) begin
            tick();
            cycles++;
        end
        check({name, "_drained_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin : main
        int cyc;
        src_en = '0; s_src_tvalid = '0; s_src_tdata = '0; m_tready = 1'b1;

        // Reset state, with every source requesting during reset
        src_en = 4'hF; s_src_tvalid = 4'hF;
        aresetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(rdy1), 64'd0);
        check("rst_tvalid", 64'(mv1), 64'd0);
        check("rst_tdata", 64'(md1), 64'd0);
        check("rst_tid", 64'(mt1), 64'd0);
        check("rst_grant_valid", 64'(gv1), 64'd0);
        check("rst_grant_idx", 64'(gi1), 64'd0);
        check("rst_pair_cnt", 64'(pc1), 64'd0);
        check("rst_state", 64'(st1), 64'd0);
        do_reset();

        // Src0 only: pair timing, IDLE gap, output stall with tready low for 4 cycles, enable gating
        vecs[0]  = '{4'h1, 4'h1, 16'h1111, 1'b1, 4'h0, 1'b0, 32'h0,         3'd0, 1'b1, 2'd0, 32'd0};
        vecs[1]  = '{4'h1, 4'h1, 16'h1111, 1'b1, 4'h1, 1'b1, 32'h0000_1111, 3'd0, 1'b1, 2'd0, 32'd0};
        vecs[2]  = '{4'h1, 4'h1, 16'h2222, 1'b1, 4'h1, 1'b1, 32'h0000_2222, 3'd1, 1'b0, 2'd0, 32'd1};
        vecs[3]  = '{4'h1, 4'h1, 16'h3333, 1'b1, 4'h0, 1'b0, 32'h0,         3'd0, 1'b1, 2'd0, 32'd1};
        vecs[4]  = '{4'h1, 4'h1, 16'h3333, 1'b1, 4'h1, 1'b1, 32'h0000_3333, 3'd0, 1'b1, 2'd0, 32'd1};
        vecs[5]  = '{4'h1, 4'h1, 16'h4444, 1'b1, 4'h1, 1'b1, 32'h0000_4444, 3'd1, 1'b0, 2'd0, 32'd2};
        vecs[6]  = '{4'h1, 4'h1, 16'hABCD, 1'b1, 4'h0, 1'b0, 32'h0,         3'd0, 1'b1, 2'd0, 32'd2};
        vecs[7]  = '{4'h1, 4'h1, 16'hABCD, 1'b1, 4'h1, 1'b1, 32'h0000_ABCD, 3'd0, 1'b1, 2'd0, 32'd2};
        for (int i = 8; i < 12; i++)
            vecs[i] = '{4'h1, 4'h1, 16'h5555, 1'b0, 4'h0, 1'b1, 32'h0000_ABCD, 3'd0, 1'b1, 2'd0, 32'd2};
        vecs[12] = '{4'h1, 4'h1, 16'h5555, 1'b1, 4'h1, 1'b1, 32'h0000_5555, 3'd1, 1'b0, 2'd0, 32'd3};
        vecs[13] = '{4'h1, 4'h0, 16'h5555, 1'b1, 4'h0, 1'b0, 32'h0,         3'd0, 1'b0, 2'd0, 32'd3};
        vecs[14] = '{4'h0, 4'h0, 16'h5555, 1'b1, 4'h0, 1'b0, 32'h0,         3'd0, 1'b0, 2'd0, 32'd3};
        vecs[15] = '{4'h0, 4'h1, 16'h6666, 1'b1, 4'h0, 1'b0, 32'h0,         3'd0, 1'b0, 2'd0, 32'd3};
        for (int i = 0; i < 16; i++) begin
            src_en       = vecs[i].en;
            s_src_tvalid = vecs[i].vld;
            s_src_tdata  = '0;
            s_src_tdata[15:0] = vecs[i].d0;
            m_tready     = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d_src_ready", i), 64'(rdy1), 64'(vecs[i].e_rdy));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_tvalid", i), 64'(mv1), 64'(vecs[i].e_mv));
            if (vecs[i].e_mv) begin
                check($sformatf("vec%0d_tdata", i), 64'(md1), 64'(vecs[i].e_d));
                check($sformatf("vec%0d_tid", i), 64'(mt1), 64'(vecs[i].e_tid));
            end
            check($sformatf("vec%0d_grant_valid", i), 64'(gv1), 64'(vecs[i].e_gv));
            check($sformatf("vec%0d_grant_idx", i), 64'(gi1), 64'(vecs[i].e_gi));
            check($sformatf("vec%0d_pair_cnt", i), 64'(pc1), 64'(vecs[i].e_pc));
        end

        // Round robin over all four sources, one pair per grant: 0,1,2,3,0
        do_reset();
        use3 = 1'b0;
        src_en = 4'hF; s_src_tvalid = 4'hF; m_tready = 1'b1;
        update_src();
        push_pair(0, 16'd0, 1'b0);
        push_pair(1, 16'd0, 1'b0);
        push_pair(2, 16'd0, 1'b0);
        push_pair(3, 16'd0, 1'b0);
        push_pair(0, 16'd2, 1'b0);
        sb_on = 1'b1;
        drain("rr4", 60, cyc);
        sb_on = 1'b0;
        check("rr4_cycles", 64'(cyc), 64'd16);
        check("rr4_pair_cnt", 64'(pc1), 64'd5);
        check("rr4_onehot_viol", 64'(onehot_viol), 64'd0);

        // Reset mid-pair clears the slot and the grant
        aresetn = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_tvalid", 64'(mv1), 64'd0);
        check("midrst_grant_valid", 64'(gv1), 64'd0);
        check("midrst_pair_cnt", 64'(pc1), 64'd0);
        check("midrst_ready", 64'(rdy1), 64'd0);

        // PAIRS_PER_GRANT = 3: src1 then src2, six beats each with no bubble inside a grant
        do_reset();
        use3 = 1'b1;
        src_en = 4'b0110; s_src_tvalid = 4'b0110; m_tready = 1'b1;
        update_src();
        push_pair(1, 16'd0, 1'b0);
        push_pair(1, 16'd2, 1'b0);
        push_pair(1, 16'd4, 1'b0);
        push_pair(2, 16'd0, 1'b0);
        push_pair(2, 16'd2, 1'b0);
        push_pair(2, 16'd4, 1'b0);
        sb_on = 1'b1;
        drain("ppg3", 60, cyc);
        sb_on = 1'b0;
        check("ppg3_cycles", 64'(cyc), 64'd15);
        check("ppg3_pair_cnt", 64'(pc3), 64'd6);
        use3 = 1'b0;

        // Src2 stalls between its left and right beat while src0 requests
        do_reset();
        src_en = 4'b0101; s_src_tvalid = 4'b0100; m_tready = 1'b1;
        update_src();
        push_pair(2, 16'd0, 1'b0);
        push_pair(0, 16'd0, 1'b0);
        sb_on = 1'b1;
        tick();
        #1;
        check("stall_ready_left", 64'(rdy1), 64'b0100);
        tick();
        s_src_tvalid = 4'b0001;
        forbid = 4'b0001;
        repeat (5) tick();
        check("stall_out_idle", 64'(mv1), 64'd0);
        check("stall_grant_valid", 64'(gv1), 64'd1);
        check("stall_grant_idx", 64'(gi1), 64'd2);
        check("stall_state_right", 64'(st1), 64'd2);
        s_src_tvalid = 4'b0101;
        #1;
        check("stall_ready_right", 64'(rdy1), 64'b0100);
        tick();
        forbid = '0;
        drain("stall", 40, cyc);
        sb_on = 1'b0;
        check("stall_forbidden_ready", 64'(forb_viol), 64'd0);
        check("stall_pair_cnt", 64'(pc1), 64'd2);

`ifdef AUD_SCHED_MUTE_EN
        // Muted src1 loses its PCM half; src0 passes through
        do_reset();
        src_en = 4'b0011; s_src_tvalid = 4'b0011; m_tready = 1'b1;
        mute_mask = 4'b0010;
        src_hi[0] = 16'h00A0; seq[0] = 16'h1234;
        src_hi[1] = 16'h0005; seq[1] = 16'h7FFF;
        update_src();
        push_pair(0, 16'h1234, 1'b0);
        push_pair(1, 16'h7FFF, 1'b1);
        sb_on = 1'b1;
        drain("mute", 40, cyc);
        sb_on = 1'b0;
        check("mute_pair_cnt", 64'(pc1), 64'd2);
`endif

        check("final_onehot_viol", 64'(onehot_viol), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
